// File: rtl/bsg_fifo_1r1w_commit.sv
// FIFO with a speculative write side: enqueued entries stay invisible to the
// reader until committed, and a squash rewinds the write pointer to the last commit.
module bsg_fifo_1r1w_commit #(
  parameter int width_p = 8,
  parameter int els_p   = 4,
  localparam int ptr_width_lp = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic                    commit_v_i,
  input  logic                    squash_v_i,
  output logic [width_p-1:0]      data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [ptr_width_lp:0]   pending_count_o,
  output logic [ptr_width_lp:0]   committed_count_o
);

  typedef logic [ptr_width_lp:0] ptr_t;

  ptr_t wptr_r, cptr_r, rptr_r;
  ptr_t wptr_next, cptr_next, rptr_next, wptr_plus;

  logic full, empty, enq, deq;
  logic [width_p-1:0] mem_r [els_p];

  // Full compares against the read pointer, not the commit pointer: pending
  // entries occupy storage even though the reader cannot see them yet.
  assign full  = (wptr_r[ptr_width_lp-1:0] == rptr_r[ptr_width_lp-1:0])
              && (wptr_r[ptr_width_lp] != rptr_r[ptr_width_lp]);
  assign empty = (rptr_r == cptr_r);

  assign ready_o = ~full & ~squash_v_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i;
  assign v_o     = ~empty;

  assign wptr_plus = wptr_r + ptr_t'(enq);
  assign rptr_next = rptr_r + ptr_t'(deq);
  assign cptr_next = commit_v_i ? wptr_plus : cptr_r;
  // Squash rewinds to the post-commit point, so commit+squash leaves wptr in place.
  assign wptr_next = squash_v_i ? cptr_next : wptr_plus;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      cptr_r <= '0;
      rptr_r <= '0;
    end else begin
      wptr_r <= wptr_next;
      cptr_r <= cptr_next;
      rptr_r <= rptr_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[ptr_width_lp-1:0]] <= data_i;
  end

  assign data_o = mem_r[rptr_r[ptr_width_lp-1:0]];

  assign pending_count_o   = wptr_r - cptr_r;
  assign committed_count_o = cptr_r - rptr_r;

  localparam logic [ptr_width_lp+1:0] els_lp = (ptr_width_lp+2)'(els_p);
  logic [ptr_width_lp+1:0] occupancy;
  assign occupancy = {1'b0, pending_count_o} + {1'b0, committed_count_o};

  a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && !v_o));
  a_occupancy_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    occupancy <= els_lp);

endmodule

// File: tb/tb_bsg_fifo_1r1w_commit.sv
// Bench for bsg_fifo_1r1w_commit: directed scenarios then random traffic,
// checked against a two-queue (pending / committed) reference model.
module tb_bsg_fifo_1r1w_commit;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [W-1:0] data_i;
  logic         v_i;
  logic         ready_o;
  logic         commit_v_i;
  logic         squash_v_i;
  logic [W-1:0] data_o;
  logic         v_o;
  logic         yumi_i;
  logic [2:0]   pending_count_o;
  logic [2:0]   committed_count_o;

  bsg_fifo_1r1w_commit #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .data_i(data_i), .v_i(v_i),
    .ready_o(ready_o), .commit_v_i(commit_v_i), .squash_v_i(squash_v_i),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
    .pending_count_o(pending_count_o), .committed_count_o(committed_count_o)
  );

  always #5 clk_i = ~clk_i;

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] pq[$];  // uncommitted, in write order
  logic [W-1:0] cq[$];  // committed, unread, head at index 0

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic s);
    logic exp_ready;
    exp_ready = ((cq.size() + pq.size()) < N) && !s;
    chk({tag, ".ready"}, 32'(ready_o), 32'(exp_ready));
    chk({tag, ".v_o"}, 32'(v_o), 32'(cq.size() != 0));
    if (cq.size() != 0) chk({tag, ".data_o"}, 32'(data_o), 32'(cq[0]));
    chk({tag, ".pending"}, 32'(pending_count_o), 32'(pq.size()));
    chk({tag, ".committed"}, 32'(committed_count_o), 32'(cq.size()));
  endtask

  // One clock cycle: drive at negedge, check before the posedge, update model.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                      input logic c, input logic s, input logic y);
    logic yy, enq;
    yy = y && (cq.size() != 0);
    v_i = v; data_i = d; commit_v_i = c; squash_v_i = s; yumi_i = yy;
    #1;
    check_outputs(tag, s);
    enq = v && ((cq.size() + pq.size()) < N) && !s;
    $display("[%0t] %s v=%0b d=%02h c=%0b s=%0b y=%0b enq=%0b pend=%0d comm=%0d",
             $time, tag, v, d, c, s, yy, enq, pq.size(), cq.size());
    @(posedge clk_i);
    if (yy) void'(cq.pop_front());
    if (enq) pq.push_back(d);
    if (c) begin
      while (pq.size() != 0) cq.push_back(pq.pop_front());
    end else if (s) begin
      pq.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    v_i = 1'b0; data_i = '0; commit_v_i = 1'b0; squash_v_i = 1'b0; yumi_i = 1'b0;
    @(negedge clk_i);
    #1;
    check_outputs("reset", 1'b0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Four tentative writes fill the FIFO; commit makes them visible next cycle.
    for (int i = 0; i < N; i++) step("fill", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle("full_probe");
    step("commit_all", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("after_commit");
    for (int i = 0; i < N; i++) step("drain", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle("drained");

    // Commit 11,22; squash 33,44; then 55 must follow 22 directly.
    step("w11", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step("w22", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step("c1", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("w33", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step("w44", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step("sq", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("r11", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("r22", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("w55c", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step("r55", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Write and commit in the same cycle on an empty FIFO.
    step("w66c", 1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    step("r66", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Commit+squash together with two pending and a write offered.
    step("w77", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step("w88", 1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    step("cs99", 1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    idle("after_cs");
    step("r77", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("r88", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Push pointers past the wrap point, then squash across it.
    for (int i = 0; i < 10; i++) begin
      step("wrap_wc", 1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
      step("wrap_rd", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    step("wrap_w1", 1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
    step("wrap_w2", 1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
    step("wrap_w3", 1'b1, 8'hD3, 1'b0, 1'b0, 1'b0);
    step("wrap_sq", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle("wrap_post_sq");
    step("wrap_w4c", 1'b1, 8'hD4, 1'b1, 1'b0, 1'b1);
    step("wrap_rd4", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle("wrap_empty");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-cycle with 3 committed and 1 pending.
    while (cq.size() != 0) step("pre_rst_drain", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("pre_rst_sq", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("pre_rst_w", 1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step("pre_rst_c", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("pre_rst_wp", 1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
    v_i = 1'b1; data_i = 8'hF0;
    #2;
    reset_n_i = 1'b0;
    #1;
    cq.delete();
    pq.delete();
    check_outputs("async_rst", 1'b0);
    v_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    idle("post_rst");
    step("post_rst_w", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    step("post_rst_r", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_1r1w_commit.md
Name: bsg_fifo_1r1w_commit

Overview:
- FIFO whose write side is speculative and whose read side is plain; it is the writer-side counterpart of the rollback-read FIFO.
- The producer enqueues tentatively. It then either commits all pending entries, making them visible to the reader, or squashes them, rewinding the write pointer to the last commit point.
- The consumer sees only committed entries, through a valid/yumi handshake.
- Used between speculative producers (fetch, decode) and non-speculative consumers.

Parameters:
- width_p, none (must be set), data width in bits.
- els_p, none (must be set), entry count; power of two, >= 2.
- ptr_width_lp, clog2(els_p) (localparam), index width. Every pointer carries one extra wrap bit: ptr_width_lp+1 bits, cycling through 2*els_p slots.

Ports:
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous active-low reset.
- data_i  in  width_p  write data.
- v_i  in  1  write valid.
- ready_o  out  1  write ready; the write side is valid-then-ready.
- commit_v_i  in  1  commit all pending entries, including any enq in the same cycle.
- squash_v_i  in  1  discard all uncommitted entries.
- data_o  out  width_p  head committed entry; combinational from rptr.
- v_o  out  1  committed entry available.
- yumi_i  in  1  consume head; legal only when v_o=1.
- pending_count_o  out  ptr_width_lp+1  number of uncommitted entries.
- committed_count_o  out  ptr_width_lp+1  number of committed, unread entries.

Behaviour:
- State: wptr_r (speculative write pointer), cptr_r (commit pointer), rptr_r (read pointer). All are ptr_width_lp+1 bits wide and wrap modulo 2*els_p.
- Memory is bsg_mem_1r1w with els_p entries, synchronous write, asynchronous read.
  - Write address is wptr_r low bits; read address is rptr_r low bits.
- Reset (reset_n_i=0, asynchronous, any cycle):
  - wptr_r=cptr_r=rptr_r=0, so ready_o=1, v_o=0 and both counts are 0.
  - Entries in flight at reset, pending or committed, are lost. Memory contents are don't-care.
- full = (wptr_r low bits == rptr_r low bits) and (wrap bits differ). Space is freed only by reads; squash also frees space by rewinding wptr_r.
- empty = (rptr_r == cptr_r), all bits. The reader never sees pending entries.
- ready_o = ~full & ~squash_v_i.
- enq = v_i & ready_o. The memory write occurs on enq.
- deq = yumi_i. yumi_i with v_o=0 is illegal; flag it with an assertion.
- v_o = ~empty. data_o is the memory word at rptr_r, valid whenever v_o=1.
- Next-state:
  - rptr_r += deq.
  - If squash_v_i: wptr_r <= cptr_r_next; else wptr_r += enq.
  - If commit_v_i: cptr_r <= wptr_r + enq; else cptr_r unchanged.
  - cptr_r_next is the commit pointer value being written this cycle. With commit and squash together it equals wptr_r, so wptr_r is unchanged.
- Commit latency: an entry committed in cycle N (written earlier or in N) raises v_o in cycle N+1.
- Commit with nothing pending is a no-op. Squash with nothing pending is a no-op.
- commit_v_i and squash_v_i in the same cycle:
  - Entries already pending are committed.
  - No write is accepted that cycle (ready_o=0).
  - Result: cptr_r <= wptr_r and pending becomes 0.
- squash_v_i with v_i=1: the write is rejected (ready_o=0) and must be re-presented later.
- Reads are independent of commit and squash. A deq in the same cycle as either one behaves normally; cptr_r is never behind rptr_r.
- Counts:
  - pending_count_o = wptr_r - cptr_r (modulo 2*els_p).
  - committed_count_o = cptr_r - rptr_r.
  - Invariant: pending_count_o + committed_count_o <= els_p.
  - full when the sum == els_p.
- Wrap-around: pointer arithmetic is modulo 2*els_p. Squash across the wrap boundary (cptr_r wrap bit != wptr_r wrap bit) must restore exactly cptr_r.
- Assertions:
  - No yumi_i when v_o=0.
  - pending_count_o + committed_count_o <= els_p at all times.

Test Plan:
- Reset, then write A0..A3 with no commit (els_p=4, width_p=8) -> v_o stays 0, ready_o=0 after the 4th write, pending_count_o=4. Assert commit_v_i -> next cycle v_o=1, data_o=A0, committed_count_o=4, pending_count_o=0.
- Write 11,22; commit; write 33,44; squash -> reads return 11, then 22, then v_o=0. A following write of 55 plus commit -> the next read returns 55 (no 33/44).
- Same-cycle v_i=1 data 66 with commit_v_i=1 on an empty FIFO -> 66 accepted. v_o=1 in the following cycle with data_o=66.
- Commit and squash together with 2 pending entries and v_i=1 -> ready_o=0, that write is dropped, pending_count_o=0, committed_count_o=2.
- Wrap: run 10 write/commit/read cycles so that pointers pass 2*els_p. Then write 2 entries and squash -> wptr_r equals cptr_r including the wrap bit, and FIFO order is preserved.
- Assert reset_n_i low asynchronously mid-burst with 3 committed and 1 pending -> v_o=0, ready_o=1 and both counts 0 immediately, without waiting for a clock edge.
